iob_vexriscv_dbus_bridge: RTL

Downstream stage of the VexRiscv CPU wrapper's data port. Converts the core's simple dBus command/response protocol (valid/ready, wr, size, address, data) into the native IOb memory interface (valid, address, wdata, wstrb, ready, rdata). Generates byte strobes and replicates write data from the access size. Supports one outstanding transaction, rejects misaligned accesses, and feeds the system interconnect.

---
 rtl/iob_vexriscv_dbus_bridge_pkg.sv | 50 +++++
 rtl/iob_vexriscv_dbus_bridge_if.sv | 36 +++
 rtl/iob_vexriscv_dbus_bridge_lane.sv | 16 +
 rtl/iob_vexriscv_dbus_bridge.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/iob_vexriscv_dbus_bridge_pkg.sv
// Shared encodings and lane helpers for the VexRiscv dBus to IOb bridge.
// Access-size codes, FSM state encoding, strobe/replication/misalign functions.
package iob_vexriscv_dbus_bridge_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dbus_state_t;

   function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] strb;
      strb = 4'b0000;
      case (size)
         SIZE_B:  strb = 4'b0001 << addr_lo;
         SIZE_H:  strb = 4'b0011 << {addr_lo[1], 1'b0};
         SIZE_W:  strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
      logic [31:0] wdata;
      wdata = data;
      case (size)
         SIZE_B:  wdata = {4{data[7:0]}};
         SIZE_H:  wdata = {2{data[15:0]}};
         default: wdata = data;
      endcase
      return wdata;
   endfunction

   function automatic logic lane_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b1;
      case (size)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = addr_lo[0];
         SIZE_W:  bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/iob_vexriscv_dbus_bridge_if.sv
// Bus bundle between the CPU dBus, the bridge and the IOb memory side.
// slave = bridge view, master = CPU/memory environment view.
interface iob_vexriscv_dbus_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                cpu_cmd_valid;
   logic                cpu_cmd_ready;
   logic                cpu_cmd_wr;
   logic [1:0]          cpu_cmd_size;
   logic [ADDR_W-1:0]   cpu_cmd_address;
   logic [DATA_W-1:0]   cpu_cmd_data;
   logic                cpu_rsp_ready;
   logic [DATA_W-1:0]   cpu_rsp_data;
   logic                cpu_rsp_error;
   logic                mem_valid;
   logic [ADDR_W-1:0]   mem_address;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_wstrb;
   logic                mem_ready;
   logic [DATA_W-1:0]   mem_rdata;

   modport slave (
      input  cpu_cmd_valid, cpu_cmd_wr, cpu_cmd_size, cpu_cmd_address, cpu_cmd_data,
      output cpu_cmd_ready, cpu_rsp_ready, cpu_rsp_data, cpu_rsp_error,
      output mem_valid, mem_address, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport master (
      output cpu_cmd_valid, cpu_cmd_wr, cpu_cmd_size, cpu_cmd_address, cpu_cmd_data,
      input  cpu_cmd_ready, cpu_rsp_ready, cpu_rsp_data, cpu_rsp_error,
      input  mem_valid, mem_address, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/iob_vexriscv_dbus_bridge_lane.sv
// Combinational lane mapper: access size and address low bits to byte strobes,
// replicated write data and the misaligned flag.
module iob_vexriscv_dbus_bridge_lane
   import iob_vexriscv_dbus_bridge_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic        misalign
);
   assign wstrb    = lane_strb(size, addr_lo);
   assign wdata    = lane_wdata(size, data);
   assign misalign = lane_misaligned(size, addr_lo);
endmodule

// File: rtl/iob_vexriscv_dbus_bridge.sv
// VexRiscv dBus to IOb bridge, one outstanding access, misaligned commands rejected.
// Optional bus watchdog with sticky timeout_err output when DBUS_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | ready for a CPU command
// BUSY  | IOb request held on mem_* until mem_ready (or watchdog expiry)
// RESP  | one-cycle read response (data or error) to the CPU
module iob_vexriscv_dbus_bridge
   import iob_vexriscv_dbus_bridge_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT_W = 8
) (
   input  logic clk,
   input  logic rst,
   iob_vexriscv_dbus_bridge_if.slave bus,
`ifdef DBUS_TIMEOUT_EN
   output logic timeout_err,
`endif
   output logic misalign
);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("iob_vexriscv_dbus_bridge supports DATA_W = 32 only");
   end
   if (TIMEOUT_W < 2) begin : g_bad_timeout_w
      $error("iob_vexriscv_dbus_bridge needs TIMEOUT_W >= 2");
   end

   dbus_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        wstrb_q;
   logic [31:0]       wdata_q;
   logic              wr_q;
   logic [31:0]       rsp_data_q;
   logic              rsp_err_q;
   logic              misalign_q;

   logic [3:0]        lane_wstrb;
   logic [31:0]       lane_wdata;
   logic              lane_misalign;
   logic              accept;
   logic              timeout_hit;

   iob_vexriscv_dbus_bridge_lane u_lane (
      .size     (bus.cpu_cmd_size),
      .addr_lo  (bus.cpu_cmd_address[1:0]),
      .data     (bus.cpu_cmd_data),
      .wstrb    (lane_wstrb),
      .wdata    (lane_wdata),
      .misalign (lane_misalign)
   );

   assign accept = bus.cpu_cmd_valid && (state_q == IDLE);

`ifdef DBUS_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   logic [TIMEOUT_W-1:0] tmo_cnt_q;
   logic                 timeout_err_q;

   // Expire on the BUSY cycle whose increment would reach all-ones.
   assign timeout_hit = (state_q == BUSY) && !bus.mem_ready && (tmo_cnt_q == TMO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (state_q != BUSY) begin
            tmo_cnt_q <= '0;
         end else if (!bus.mem_ready) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end
         if (timeout_hit) begin
            timeout_err_q <= 1'b1;
         end
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (!lane_misalign) begin
                  state_d = BUSY;
               end else if (!bus.cpu_cmd_wr) begin
                  state_d = RESP;
               end
            end
         end
         BUSY: begin
            if (bus.mem_ready || timeout_hit) begin
               state_d = wr_q ? IDLE : RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wstrb_q    <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         misalign_q <= 1'b0;
         if (accept) begin
            misalign_q <= lane_misalign;
            rsp_data_q <= '0;
            rsp_err_q  <= lane_misalign;
            if (!lane_misalign) begin
               addr_q  <= {bus.cpu_cmd_address[ADDR_W-1:2], 2'b00};
               wstrb_q <= bus.cpu_cmd_wr ? lane_wstrb : 4'b0000;
               wdata_q <= lane_wdata;
               wr_q    <= bus.cpu_cmd_wr;
            end
         end else if (state_q == BUSY) begin
            if (bus.mem_ready) begin
               rsp_data_q <= bus.mem_rdata;
               rsp_err_q  <= 1'b0;
            end else if (timeout_hit) begin
               rsp_data_q <= '0;
               rsp_err_q  <= 1'b1;
            end
         end
      end
   end

   assign bus.cpu_cmd_ready = (state_q == IDLE);
   assign bus.cpu_rsp_ready = (state_q == RESP);
   assign bus.cpu_rsp_data  = rsp_data_q;
   assign bus.cpu_rsp_error = rsp_err_q;
   assign bus.mem_valid     = (state_q == BUSY);
   assign bus.mem_address   = addr_q;
   assign bus.mem_wdata     = wdata_q;
   assign bus.mem_wstrb     = wstrb_q;
   assign misalign          = misalign_q;

endmodule
